// File: rtl/sized_data_memory_pkg.sv
// Shared definitions for the sized data memory: access-size encodings, sweep
// FSM states and the lane/size helpers used by the store and load paths.
package sized_data_memory_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  // Lane offset must be a multiple of the access size; lane is zero-extended to 3 bits.
  function automatic logic lane_aligned(input logic [2:0] lane, input logic [1:0] size);
    case (size)
      SIZE_B:  return 1'b1;
      SIZE_H:  return lane[0] == 1'b0;
      SIZE_W:  return lane[1:0] == 2'b00;
      default: return lane == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sized_data_memory_load_align.sv
// Load alignment: shifts the addressed bytes of a word down to bit 0 and
// fills the upper bits with zero or the access's sign bit.
module mem_load_align
  import sized_data_memory_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int BIT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] shifted;
  int                n_bits;
  logic [BIT_W-1:0]  msb_idx;
  logic              ext_bit;

  always_comb begin
    shifted = word_i >> {lane_i, 3'b000};
    n_bits  = size_bytes(size_i) * 8;
    if (n_bits > DATA_W) begin
      n_bits = DATA_W;
    end
    msb_idx = BIT_W'(n_bits - 1);
    ext_bit = signed_i & shifted[msb_idx];
  end

  // A full-width access never reaches the fill branch, so signedness is moot there.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    assign data_o[gi] = (gi < n_bits) ? shifted[gi] : ext_bit;
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed data memory with sized, aligned loads/stores, write-first
// forwarding, a registered load port and a one-word-per-cycle clear sweep.
module sized_data_memory
  import sized_data_memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH * DATA_W / 8)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemSigned,
  input  logic              Clear,
  output logic [DATA_W-1:0] ReadData,
  output logic              ReadValid,
  output logic              Misaligned,
  output logic              Busy
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q;
  logic [IDX_W-1:0]  sweep_idx_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              mis_q;

  logic [IDX_W-1:0]  word_idx;
  logic [LANE_W-1:0] lane;
  int                acc_bytes;
  logic              req;
  logic              aligned;
  logic              oversize;
  logic              reject;
  logic              store_en;
  logic              load_en;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wdata_shift;
  logic [BYTES-1:0]  byte_en;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] rdata_d;

  assign word_idx  = Address[LANE_W +: IDX_W];
  assign lane      = Address[LANE_W-1:0];
  assign acc_bytes = size_bytes(MemSize);

  // A Clear pulse claims the cycle, so any request alongside it is rejected.
  assign req      = MemRead | MemWrite;
  assign aligned  = lane_aligned(3'(lane), MemSize);
  assign oversize = acc_bytes > BYTES;
  assign reject   = req & (busy_q | Clear | ~aligned | oversize);
  assign store_en = MemWrite & ~reject;
  assign load_en  = MemRead & ~reject;

  assign rd_word     = mem_q[word_idx];
  assign wdata_shift = WriteData << {lane, 3'b000};

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign byte_en[gi] = (gi >= int'(lane)) && (gi < int'(lane) + acc_bytes);
    assign merged[gi*8 +: 8] = byte_en[gi] ? wdata_shift[gi*8 +: 8] : rd_word[gi*8 +: 8];
  end

  // Write-first: a load paired with a store sees the merged word.
  assign load_word = store_en ? merged : rd_word;

  mem_load_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .word_i  (load_word),
    .lane_i  (lane),
    .size_i  (MemSize),
    .signed_i(MemSigned),
    .data_o  (load_data)
  );

  assign rdata_d = load_en ? load_data : rdata_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      sweep_idx_q <= '0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= load_en;
      mis_q    <= reject;
      case (state_q)
        ST_IDLE: begin
          if (Clear) begin
            state_q     <= ST_CLEAR;
            sweep_idx_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        ST_CLEAR: begin
          sweep_idx_q <= sweep_idx_q + 1'b1;
          if (sweep_idx_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Array has no reset so a reset mid-sweep leaves the unswept words intact.
  always_ff @(posedge Clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[sweep_idx_q] <= '0;
    end else if (store_en) begin
      mem_q[word_idx] <= merged;
    end
  end

  assign ReadData   = rdata_q;
  assign ReadValid  = rvalid_q;
  assign Misaligned = mis_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_sized_data_memory.sv
// Bench for sized_data_memory (DATA_W=32, DEPTH=128): directed and random
// accesses checked against a byte-array model of the memory.
module tb_sized_data_memory;

  localparam int DEPTH = 128;
  localparam int NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  address = '0;
  logic [31:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = '0;
  logic        mem_signed = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        misaligned;
  logic        busy;

  int checks = 0;
  int passed = 0;

  logic [7:0]  mbytes [NBYTE];
  int          busy_left = 0;
  logic [31:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  logic        exp_mis = 1'b0;

  sized_data_memory dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Address   (address),
    .WriteData (write_data),
    .MemRead   (mem_read),
    .MemWrite  (mem_write),
    .MemSize   (mem_size),
    .MemSigned (mem_signed),
    .Clear     (clear),
    .ReadData  (read_data),
    .ReadValid (read_valid),
    .Misaligned(misaligned),
    .Busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] model_load(input int addr, input int nb, input bit sgn);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = mbytes[addr + k];
    if (sgn && nb < 4 && v[8*nb-1]) begin
      for (int k = 8 * nb; k < 32; k++) v[k] = 1'b1;
    end
    return v;
  endfunction

  // One clock cycle: drive a request, update the model, check all outputs.
  task automatic step(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                      input int addr, input logic [31:0] wd, input bit clr);
    int nb;
    bit req;
    bit legal;
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    mem_size   = sz;
    mem_signed = sgn;
    address    = 9'(addr);
    write_data = wd;
    clear      = clr;
    nb    = 1 << sz;
    req   = rd || wr;
    legal = req && busy_left == 0 && !clr && sz != 2'd3 && (addr % nb) == 0;
    exp_valid = legal && rd;
    exp_mis   = req && !legal;
    if (legal && wr) begin
      for (int k = 0; k < nb; k++) mbytes[addr + k] = wd[8*k +: 8];
    end
    if (legal && rd) exp_data = model_load(addr, nb, sgn);
    if (busy_left > 0) begin
      for (int k = 0; k < 4; k++) mbytes[4 * (DEPTH - busy_left) + k] = 8'h00;
      busy_left--;
    end else if (clr) begin
      busy_left = DEPTH;
    end
    @(posedge clk);
    #1;
    check("ReadValid", {31'b0, read_valid}, {31'b0, exp_valid});
    check("Misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
    check("Busy", {31'b0, busy}, {31'b0, busy_left > 0});
    check("ReadData", read_data, exp_data);
    if (req || clr) begin
      $display("t=%0t rd=%0b wr=%0b clr=%0b sz=%0d sgn=%0b addr=0x%03h wd=0x%08h -> valid=%0b data=0x%08h mis=%0b busy=%0b",
               $time, rd, wr, clr, sz, sgn, addr, wd, read_valid, read_data, misaligned, busy);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    int          addr;
    int          op;
    logic [1:0]  sz;
    for (int i = 0; i < NBYTE; i++) mbytes[i] = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ReadData", read_data, 32'h0);
    check("rst_ReadValid", {31'b0, read_valid}, 32'h0);
    check("rst_Misaligned", {31'b0, misaligned}, 32'h0);
    check("rst_Busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero the array so every later load has a defined reference
    step(0, 0, 2'd0, 0, 0, 32'h0, 1);
    idle(DEPTH);

    // Signed byte load of a stored word
    step(0, 1, 2'd2, 0, 'h10, 32'h8000_00F0, 0);
    step(1, 0, 2'd0, 1, 'h10, 32'h0, 0);
    check("byte_signed", read_data, 32'hFFFF_FFF0);
    idle(1);
    step(1, 0, 2'd0, 0, 'h13, 32'h0, 0);
    check("byte_unsigned_top", read_data, 32'h0000_0080);

    // Half store merges into an existing word
    step(0, 1, 2'd2, 0, 'h20, 32'hAABB_CCDD, 0);
    step(0, 1, 2'd1, 0, 'h22, 32'h0000_1234, 0);
    step(1, 0, 2'd2, 0, 'h20, 32'h0, 0);
    check("half_merge", read_data, 32'h1234_CCDD);
    step(1, 0, 2'd1, 1, 'h20, 32'h0, 0);
    check("half_signed", read_data, 32'hFFFF_CCDD);

    // Misaligned and oversize requests leave memory untouched
    step(1, 0, 2'd1, 0, 'h21, 32'h0, 0);
    step(1, 0, 2'd2, 0, 'h22, 32'h0, 0);
    step(0, 1, 2'd2, 0, 'h22, 32'hFFFF_FFFF, 0);
    step(0, 1, 2'd3, 0, 'h20, 32'hFFFF_FFFF, 0);
    step(1, 0, 2'd2, 0, 'h20, 32'h0, 0);
    check("after_reject", read_data, 32'h1234_CCDD);

    // Same-cycle store and load: write-first
    step(1, 1, 2'd2, 0, 'h40, 32'hDEAD_BEEF, 0);
    check("write_first", read_data, 32'hDEAD_BEEF);
    step(1, 1, 2'd0, 1, 'h45, 32'h0000_0099, 0);
    check("write_first_byte", read_data, 32'hFFFF_FF99);

    // Random traffic over the low 128 bytes
    for (int i = 0; i < 300; i++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom_range(0, 127);
      if ($urandom_range(0, 3) != 0) addr = addr & ~((1 << sz) - 1);
      op = $urandom_range(0, 2);
      step(op != 1, op != 0, sz, 1'($urandom_range(0, 1)), addr, $urandom, 0);
    end

    // Fill, then clear with a rejected load, a load and store during the sweep and a re-Clear
    for (int w = 0; w < DEPTH; w++) step(0, 1, 2'd2, 0, 4 * w, $urandom | 32'h1, 0);
    step(1, 0, 2'd2, 0, 'h40, 32'h0, 1);
    for (int i = 1; i < DEPTH; i++) begin
      if (i == 5) step(1, 0, 2'd2, 0, 'h10, 32'h0, 0);
      else if (i == 10) step(0, 1, 2'd2, 0, 'h1F0, 32'h5555_AAAA, 0);
      else if (i == 60) step(0, 0, 2'd0, 0, 0, 32'h0, 1);
      else idle(1);
    end
    idle(1);
    check("busy_done", {31'b0, busy}, 32'h0);
    for (int w = 0; w < DEPTH; w++) step(1, 0, 2'd2, 0, 4 * w, 32'h0, 0);
    check("swept_last", read_data, 32'h0);

    // Reset 50 cycles into a sweep
    for (int w = 0; w < DEPTH; w++) step(0, 1, 2'd2, 0, 4 * w, $urandom | 32'h1, 0);
    step(0, 0, 2'd0, 0, 0, 32'h0, 1);
    idle(50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    busy_left = 0;
    exp_data  = '0;
    check("midrst_Busy", {31'b0, busy}, 32'h0);
    check("midrst_ReadData", read_data, 32'h0);
    check("midrst_ReadValid", {31'b0, read_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      step(1, 0, 2'd2, 0, 4 * w, 32'h0, 0);
      if (w == 49) check("word49_zero", read_data, 32'h0);
      if (w == 50) check("word50_kept", {31'b0, read_data != 32'h0}, 32'h1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
